// File: rtl/motor_startup_sequencer.sv
// Open-loop BLDC start-up sequencer (align -> ramp -> run, plus stop/brake); optional MOTOR_SEQ_STEP_COUNT_EN adds o_step_count.
// Latency: all outputs registered, one cycle after the sampled request or tick.
// Backpressure: none; requests are levels sampled every cycle (brake > stop > start).
module motor_startup_sequencer #(
    parameter int K_NSUBSTEPS = 10,
    parameter int K_PERIOD_W  = 16,
    parameter int K_ALIGN_W   = 20
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic                           i_brake_req,
    input  logic [2:0]                     i_align_step,
    input  logic [K_ALIGN_W-1:0]           i_align_time,
    input  logic [K_PERIOD_W-1:0]          i_period_start,
    input  logic [K_PERIOD_W-1:0]          i_period_min,
    input  logic [K_PERIOD_W-1:0]          i_period_dec,
    input  logic [$clog2(K_NSUBSTEPS)-1:0] i_power_cfg,
    output logic [2:0]                     o_force_step_value,
    output logic                           o_force_step_trigger,
    output logic                           o_step_trigger,
    output logic                           o_brake,
    output logic [$clog2(K_NSUBSTEPS)-1:0] o_power,
    output logic [2:0]                     o_state,
`ifdef MOTOR_SEQ_STEP_COUNT_EN
    output logic [15:0]                    o_step_count,
`endif
    output logic                           o_running
);

    localparam int K_SW = $clog2(K_NSUBSTEPS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_RAMP  = 3'd2,
        S_RUN   = 3'd3,
        S_BRAKE = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [K_ALIGN_W-1:0]  align_cnt, align_last_l;
    logic [K_PERIOD_W-1:0] pstart_l, pmin_l, pdec_l;
    logic [K_PERIOD_W-1:0] p_reg, tick;
    logic [K_SW-1:0]       sub_cnt;

    logic [2:0]            step_clamp;
    logic [K_PERIOD_W-1:0] min_eff, start_eff, p_next;
    logic [K_ALIGN_W-1:0]  align_last_in;
    logic [K_PERIOD_W:0]   p_diff;
    logic                  tick_end, sub_last, fire, boundary;

    assign o_state = state;

    // Configuration sanitised at latch time so the datapath never sees P=0 or start<min.
    assign step_clamp    = (i_align_step > 3'd5) ? 3'd5 : i_align_step;
    assign min_eff       = (i_period_min == '0) ? K_PERIOD_W'(1) : i_period_min;
    assign start_eff     = (i_period_start < min_eff) ? min_eff : i_period_start;
    assign align_last_in = (i_align_time == '0) ? '0 : i_align_time - K_ALIGN_W'(1);

    assign p_diff   = {1'b0, p_reg} - {1'b0, pdec_l};
    assign p_next   = (p_diff[K_PERIOD_W] || (p_diff[K_PERIOD_W-1:0] < pmin_l))
                      ? pmin_l : p_diff[K_PERIOD_W-1:0];
    assign tick_end = (tick == p_reg - K_PERIOD_W'(1));
    assign sub_last = (sub_cnt == K_SW'(K_NSUBSTEPS - 1));
    // A stop or brake in the decision cycle swallows the pending substep pulse.
    assign fire     = ((state == S_RAMP) || (state == S_RUN)) && tick_end
                      && !i_brake_req && !i_stop;
    assign boundary = fire && sub_last;

    always_comb begin
        state_nxt = state;
        if (i_brake_req) begin
            state_nxt = S_BRAKE;
        end else begin
            case (state)
                S_IDLE:  if (!i_stop && i_start) state_nxt = S_ALIGN;
                S_ALIGN: begin
                    if (i_stop)                          state_nxt = S_IDLE;
                    else if (align_cnt == align_last_l)  state_nxt = S_RAMP;
                end
                S_RAMP: begin
                    if (i_stop)                             state_nxt = S_IDLE;
                    else if (boundary && (p_reg == pmin_l)) state_nxt = S_RUN;
                end
                S_RUN:   if (i_stop) state_nxt = S_IDLE;
                S_BRAKE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                <= S_IDLE;
            o_force_step_value   <= '0;
            o_force_step_trigger <= 1'b0;
            o_step_trigger       <= 1'b0;
            o_brake              <= 1'b0;
            o_power              <= '0;
            o_running            <= 1'b0;
            align_cnt            <= '0;
            align_last_l         <= '0;
            pstart_l             <= '0;
            pmin_l               <= '0;
            pdec_l               <= '0;
            p_reg                <= '0;
            tick                 <= '0;
            sub_cnt              <= '0;
`ifdef MOTOR_SEQ_STEP_COUNT_EN
            o_step_count         <= '0;
`endif
        end else begin
            state                <= state_nxt;
            o_force_step_trigger <= (state == S_IDLE) && (state_nxt == S_ALIGN);
            o_step_trigger       <= fire;
            o_brake              <= (state_nxt == S_BRAKE);
            o_running            <= (state_nxt == S_RUN);
            o_power              <= ((state_nxt == S_ALIGN) || (state_nxt == S_RAMP) ||
                                     (state_nxt == S_RUN)) ? i_power_cfg : '0;

            if ((state == S_IDLE) && (state_nxt == S_ALIGN)) begin
                o_force_step_value <= step_clamp;
                align_last_l       <= align_last_in;
                pstart_l           <= start_eff;
                pmin_l             <= min_eff;
                pdec_l             <= i_period_dec;
            end else if (state_nxt != S_ALIGN) begin
                o_force_step_value <= '0;
            end

            align_cnt <= ((state == S_ALIGN) && (state_nxt == S_ALIGN))
                         ? align_cnt + K_ALIGN_W'(1) : '0;

            if ((state_nxt == S_RAMP) || (state_nxt == S_RUN)) begin
                if (state == S_ALIGN) begin
                    p_reg   <= pstart_l;
                    tick    <= '0;
                    sub_cnt <= '0;
                end else begin
                    tick <= tick_end ? '0 : tick + K_PERIOD_W'(1);
                    if (fire)
                        sub_cnt <= sub_last ? '0 : sub_cnt + K_SW'(1);
                    // Period only shrinks at whole-step boundaries; RUN keeps it fixed.
                    if (boundary && (state == S_RAMP))
                        p_reg <= p_next;
                end
            end else begin
                tick    <= '0;
                sub_cnt <= '0;
            end

`ifdef MOTOR_SEQ_STEP_COUNT_EN
            if (state_nxt == S_IDLE)
                o_step_count <= '0;
            else if (boundary && (o_step_count != 16'hFFFF))
                o_step_count <= o_step_count + 16'd1;
`endif
        end
    end

endmodule
